// File: rtl/vend_pkg.sv
// Shared types and coin constants for the change dispenser.
// Amounts are carried in nickel units (1 = 5c).
package vend_pkg;

  localparam int NICK_W = 4;

  localparam logic [NICK_W-1:0] VAL_Q = 4'd5;
  localparam logic [NICK_W-1:0] VAL_D = 4'd2;
  localparam logic [NICK_W-1:0] VAL_N = 4'd1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SELECT,
    ST_EJECT,
    ST_WAIT_ACK,
    ST_DONE,
    ST_FAULT
  } disp_state_t;

  typedef enum logic [1:0] {
    COIN_NONE,
    COIN_Q,
    COIN_D,
    COIN_N
  } coin_t;

  function automatic logic [NICK_W-1:0] coin_value(input coin_t c);
    case (c)
      COIN_Q:  coin_value = VAL_Q;
      COIN_D:  coin_value = VAL_D;
      COIN_N:  coin_value = VAL_N;
      default: coin_value = '0;
    endcase
  endfunction

endpackage

// File: rtl/ack_timer.sv
// Counts cycles spent waiting for a hopper acknowledge; expired when the count
// equals limit. The count saturates so it never wraps back below the limit.
module ack_timer (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       clr,
  input  logic       en,
  input  logic [7:0] limit,
  output logic       expired
);

  logic [7:0] count;

  always_ff @(posedge clk) begin
    if (!reset_n || clr) begin
      count <= '0;
    end else if (en && count != 8'hFF) begin
      count <= count + 8'd1;
    end
  end

  assign expired = (count == limit);

endmodule

// File: rtl/change_dispenser.sv
// Pays out change after a vend using greedy, stock-aware coin selection,
// one coin per hopper acknowledge, with a timeout/out-of-stock fault state.
module change_dispenser
  import vend_pkg::*;
#(
  parameter int COUNT_W     = 8,
  parameter int INIT_Q      = 20,
  parameter int INIT_D      = 20,
  parameter int INIT_N      = 40,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               soda_out,
  input  logic [NICK_W-1:0]  change_out,
  input  logic               refill,
  input  logic               coin_ack,
  output logic               q_eject,
  output logic               d_eject,
  output logic               n_eject,
  output logic               busy,
  output logic               done,
  output logic               fault,
  output logic               overrun,
  output logic [NICK_W-1:0]  owed,
  output logic [COUNT_W-1:0] q_count,
  output logic [COUNT_W-1:0] d_count,
  output logic [COUNT_W-1:0] n_count
);

  localparam logic [7:0]         LIMIT  = 8'(ACK_TIMEOUT);
  localparam logic [COUNT_W-1:0] LOAD_Q = COUNT_W'(INIT_Q);
  localparam logic [COUNT_W-1:0] LOAD_D = COUNT_W'(INIT_D);
  localparam logic [COUNT_W-1:0] LOAD_N = COUNT_W'(INIT_N);

  disp_state_t state, state_n;
  coin_t       sel, sel_n;
  logic        expired;
  logic        ack_hit;
  logic        reload;
  logic        vend_start;

  assign ack_hit    = (state == ST_WAIT_ACK) && coin_ack;
  assign reload     = refill && (state == ST_IDLE || state == ST_FAULT);
  assign vend_start = (state == ST_IDLE) && soda_out && (change_out != '0);

  ack_timer u_ack_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (state == ST_EJECT),
    .en      (state == ST_WAIT_ACK),
    .limit   (LIMIT),
    .expired (expired)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= ST_IDLE;
      sel   <= COIN_NONE;
    end else begin
      state <= state_n;
      sel   <= sel_n;
    end
  end

  always_comb begin
    state_n = state;
    sel_n   = sel;
    case (state)
      ST_IDLE: begin
        if (vend_start) state_n = ST_SELECT;
      end
      ST_SELECT: begin
        // Each candidate requires value <= owed and stock > 0, so neither
        // owed nor the counters can underflow.
        if (owed == '0) begin
          sel_n   = COIN_NONE;
          state_n = ST_DONE;
        end else if (owed >= VAL_Q && q_count != '0) begin
          sel_n   = COIN_Q;
          state_n = ST_EJECT;
        end else if (owed >= VAL_D && d_count != '0) begin
          sel_n   = COIN_D;
          state_n = ST_EJECT;
        end else if (n_count != '0) begin
          sel_n   = COIN_N;
          state_n = ST_EJECT;
        end else begin
          sel_n   = COIN_NONE;
          state_n = ST_FAULT;
        end
      end
      ST_EJECT:    state_n = ST_WAIT_ACK;
      ST_WAIT_ACK: begin
        if (coin_ack)     state_n = ST_SELECT;
        else if (expired) state_n = ST_FAULT;
      end
      ST_DONE:     state_n = ST_IDLE;
      ST_FAULT: begin
        if (refill) state_n = ST_SELECT;
      end
      default:     state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      owed <= '0;
    end else if (vend_start) begin
      owed <= change_out;
    end else if (ack_hit) begin
      owed <= owed - coin_value(sel);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n || reload) begin
      q_count <= LOAD_Q;
      d_count <= LOAD_D;
      n_count <= LOAD_N;
    end else if (ack_hit) begin
      if (sel == COIN_Q) q_count <= q_count - 1'b1;
      if (sel == COIN_D) d_count <= d_count - 1'b1;
      if (sel == COIN_N) n_count <= n_count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      overrun <= 1'b0;
    end else if (soda_out && state != ST_IDLE) begin
      overrun <= 1'b1;
    end
  end

  assign q_eject = (state == ST_EJECT) && (sel == COIN_Q);
  assign d_eject = (state == ST_EJECT) && (sel == COIN_D);
  assign n_eject = (state == ST_EJECT) && (sel == COIN_N);
  assign busy    = (state == ST_SELECT) || (state == ST_EJECT) ||
                   (state == ST_WAIT_ACK) || (state == ST_DONE);
  assign done    = (state == ST_DONE);
  assign fault   = (state == ST_FAULT);

endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench: default-stock dispenser plus a second instance with no quarters.
module tb_change_dispenser;

  localparam int T = 255;

  logic       clk = 1'b0;
  logic       reset_n, soda, refill, ack, use2;
  logic [3:0] change;

  logic       q1, d1, n1, busy1, done1, fault1, ovr1;
  logic [3:0] owed1;
  logic [7:0] qc1, dc1, nc1;
  logic       q2, d2, n2, busy2, done2, fault2, ovr2;
  logic [3:0] owed2;
  logic [7:0] qc2, dc2, nc2;

  logic       q_e, d_e, n_e, busy_m, done_m;
  logic [3:0] owed_m;
  logic [7:0] qc_m;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  change_dispenser u_dut (
    .clk(clk), .reset_n(reset_n), .soda_out(soda & ~use2), .change_out(change),
    .refill(refill), .coin_ack(ack & ~use2),
    .q_eject(q1), .d_eject(d1), .n_eject(n1), .busy(busy1), .done(done1),
    .fault(fault1), .overrun(ovr1), .owed(owed1),
    .q_count(qc1), .d_count(dc1), .n_count(nc1)
  );

  change_dispenser #(.INIT_Q(0)) u_dut_noq (
    .clk(clk), .reset_n(reset_n), .soda_out(soda & use2), .change_out(change),
    .refill(refill), .coin_ack(ack & use2),
    .q_eject(q2), .d_eject(d2), .n_eject(n2), .busy(busy2), .done(done2),
    .fault(fault2), .overrun(ovr2), .owed(owed2),
    .q_count(qc2), .d_count(dc2), .n_count(nc2)
  );

  assign q_e    = use2 ? q2 : q1;
  assign d_e    = use2 ? d2 : d1;
  assign n_e    = use2 ? n2 : n1;
  assign busy_m = use2 ? busy2 : busy1;
  assign done_m = use2 ? done2 : done1;
  assign owed_m = use2 ? owed2 : owed1;
  assign qc_m   = use2 ? qc2 : qc1;

  task automatic check(input string tag, input int obs, input int exp_v);
    checks++;
    if (obs != exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic vend(input logic [3:0] c);
    soda   = 1'b1;
    change = c;
    tick();
    soda   = 1'b0;
    change = 4'd0;
  endtask

  // Coin code: 1=Q 2=D 3=N, 4=more than one eject, 0=none within the budget.
  task automatic expect_eject(input string tag, input int coin);
    int got;
    got = 0;
    for (int i = 0; i < 8 && got == 0; i++) begin
      tick();
      if (int'(q_e) + int'(d_e) + int'(n_e) > 1) got = 4;
      else if (q_e) got = 1;
      else if (d_e) got = 2;
      else if (n_e) got = 3;
    end
    check(tag, got, coin);
  endtask

  task automatic ack_coin();
    tick();
    tick();
    ack = 1'b1;
    tick();
    ack = 1'b0;
  endtask

  initial begin
    int ej;
    reset_n = 1'b0; soda = 1'b0; refill = 1'b0; ack = 1'b0; use2 = 1'b0;
    change  = 4'd0;
    tick(); tick();
    reset_n = 1'b1;

    check("rst_busy", int'(busy1), 0);
    check("rst_done", int'(done1), 0);
    check("rst_fault", int'(fault1), 0);
    check("rst_ovr", int'(ovr1), 0);
    check("rst_owed", int'(owed1), 0);
    check("rst_ej", int'(q1 | d1 | n1), 0);
    check("rst_qc", int'(qc1), 20);
    check("rst_dc", int'(dc1), 20);
    check("rst_nc", int'(nc1), 40);

    vend(4'd15);
    check("v15_busy", int'(busy1), 1);
    check("v15_owed", int'(owed1), 15);
    for (int i = 0; i < 3; i++) begin
      expect_eject("v15_coin", 1);
      ack_coin();
      check("v15_owed_step", int'(owed1), 10 - 5 * i);
    end
    tick();
    check("v15_done", int'(done1), 1);
    check("v15_done_busy", int'(busy1), 1);
    tick();
    check("v15_done_pulse", int'(done1), 0);
    check("v15_idle_busy", int'(busy1), 0);
    check("v15_qc", int'(qc1), 17);

    vend(4'd3);
    expect_eject("v3_d", 2);
    ack_coin();
    check("v3_owed1", int'(owed1), 1);
    expect_eject("v3_n", 3);
    ack_coin();
    check("v3_owed0", int'(owed1), 0);
    tick();
    check("v3_done", int'(done1), 1);
    tick();
    check("v3_dc", int'(dc1), 19);
    check("v3_nc", int'(nc1), 39);

    ack = 1'b1;
    tick();
    ack = 1'b0;
    tick();
    check("idle_ack_busy", int'(busy1), 0);
    check("idle_ack_cnt", int'(qc1) + int'(dc1) + int'(nc1), 17 + 19 + 39);
    vend(4'd0);
    check("v0_busy", int'(busy1), 0);
    tick();
    check("v0_done", int'(done1), 0);

    vend(4'd4);
    expect_eject("v4_d", 2);
    tick();
    tick();
    refill = 1'b1;
    tick();
    refill = 1'b0;
    check("wait_refill_dc", int'(dc1), 19);
    check("wait_refill_busy", int'(busy1), 1);
    ej = 0;
    for (int i = 0; i < T - 2; i++) begin
      tick();
      if (q1 | d1 | n1) ej++;
    end
    check("to_no_eject", ej, 0);
    check("to_edge_fault", int'(fault1), 0);
    tick();
    check("to_fault", int'(fault1), 1);
    check("to_busy", int'(busy1), 0);
    check("to_owed", int'(owed1), 4);
    check("to_dc", int'(dc1), 19);
    tick();
    check("to_hold", int'(fault1), 1);
    refill = 1'b1;
    tick();
    refill = 1'b0;
    check("resume_fault", int'(fault1), 0);
    check("resume_dc", int'(dc1), 20);
    expect_eject("resume_d1", 2);
    ack_coin();
    check("resume_owed2", int'(owed1), 2);
    expect_eject("resume_d2", 2);
    ack_coin();
    tick();
    check("resume_done", int'(done1), 1);
    tick();
    check("resume_dc_end", int'(dc1), 18);

    vend(4'd2);
    expect_eject("ovr_d", 2);
    tick();
    soda = 1'b1;
    change = 4'd15;
    tick();
    soda = 1'b0;
    change = 4'd0;
    check("ovr_flag", int'(ovr1), 1);
    check("ovr_owed", int'(owed1), 2);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    check("ovr_owed0", int'(owed1), 0);
    tick();
    check("ovr_done", int'(done1), 1);
    tick();
    check("ovr_sticky", int'(ovr1), 1);

    vend(4'd5);
    expect_eject("rstmid_q", 1);
    tick();
    reset_n = 1'b0;
    tick();
    check("rstmid_busy", int'(busy1), 0);
    check("rstmid_owed", int'(owed1), 0);
    check("rstmid_ovr", int'(ovr1), 0);
    check("rstmid_ej", int'(q1 | d1 | n1), 0);
    check("rstmid_qc", int'(qc1), 20);
    reset_n = 1'b1;

    use2 = 1'b1;
    check("noq_qc", int'(qc_m), 0);
    vend(4'd5);
    expect_eject("noq_d1", 2);
    ack_coin();
    check("noq_owed3", int'(owed_m), 3);
    expect_eject("noq_d2", 2);
    ack_coin();
    check("noq_owed1", int'(owed_m), 1);
    expect_eject("noq_n", 3);
    ack_coin();
    tick();
    check("noq_done", int'(done_m), 1);
    tick();
    check("noq_idle", int'(busy_m), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
